// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD timer controller and its digit counters.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Saturating-safe BCD increment: anything at or above 9 wraps to 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single synchronous BCD digit counter (0..9) with synchronous clear and increment enable.
module bcd_digit_cnt
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] digit,
  output logic       is_nine
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (en) begin
      digit_d = bcd_inc(digit_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_nine = (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run/stop/clear controller with prescaler for a cascaded BCD digit chain; halts on a target match.
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                target_en,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] count,
  output logic [DIGITS-1:0]   cnt_en,
  output logic                running,
  output logic                done,
  output logic                overflow
);

  localparam int             PW         = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;

  logic [DIGITS-1:0] is_nine;
  logic [DIGITS-1:0] cnt_en_w;
  logic              tick;
  logic              adv;
  logic              carry_w;
  logic [3:0]        nxt_digit_w;
  logic              match_w;
  logic              all_nine;

  assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
  // stop and clear both suppress the increment that a tick would otherwise cause
  assign adv      = tick && !stop && !clear;
  assign all_nine = &is_nine;

  // Carry ripple and match against the value the count will hold after this cycle's edge.
  always_comb begin
    cnt_en_w    = '0;
    carry_w     = adv;
    match_w     = target_en;
    nxt_digit_w = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      cnt_en_w[i] = carry_w;
      nxt_digit_w = carry_w ? bcd_inc(count[4*i +: 4]) : count[4*i +: 4];
      if (target[4*i +: 4] != nxt_digit_w) begin
        match_w = 1'b0;
      end
      carry_w = carry_w && is_nine[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    overflow_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stop && start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            presc_d    = '0;
            overflow_d = all_nine;
            if (match_w) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (!stop && start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cnt u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear),
      .en     (cnt_en_w[i]),
      .digit  (count[4*i +: 4]),
      .is_nine(is_nine[i])
    );
  end

  assign cnt_en   = cnt_en_w;
  assign running  = (state_q == RUN);
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl (DIGITS=2, TICK_DIV=4): a vector table plus hand-built corner sequences.
module tb_bcd_timer_ctrl;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       start     = 1'b0;
  logic       stop      = 1'b0;
  logic       clear     = 1'b0;
  logic       target_en = 1'b0;
  logic [7:0] target    = 8'h00;
  logic [7:0] count;
  logic [1:0] cnt_en;
  logic       running;
  logic       done;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(
    .DIGITS  (DIGITS),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .target_en(target_en),
    .target   (target),
    .count    (count),
    .cnt_en   (cnt_en),
    .running  (running),
    .done     (done),
    .overflow (overflow)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] exp_count;
    logic [1:0] exp_cnt_en;
    logic       exp_running;
    logic       exp_done;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[16];

  // Drive one cycle's commands just after the rising edge, then settle before sampling.
  task automatic applyStimulus(input logic s, input logic p, input logic c);
    @(posedge clk);
    #1;
    start = s;
    stop  = p;
    clear = c;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ec, input logic [1:0] ee,
                             input logic er, input logic ed, input logic eo);
    checks++;
    if (count !== ec) begin
      errors++;
      $display("[TB] FAIL %s count: got %h expected %h", name, count, ec);
    end
    checks++;
    if (cnt_en !== ee) begin
      errors++;
      $display("[TB] FAIL %s cnt_en: got %b expected %b", name, cnt_en, ee);
    end
    checks++;
    if (running !== er) begin
      errors++;
      $display("[TB] FAIL %s running: got %b expected %b", name, running, er);
    end
    checks++;
    if (done !== ed) begin
      errors++;
      $display("[TB] FAIL %s done: got %b expected %b", name, done, ed);
    end
    checks++;
    if (overflow !== eo) begin
      errors++;
      $display("[TB] FAIL %s overflow: got %b expected %b", name, overflow, eo);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // After this, the next cycle is the first RUN cycle with prescaler 0 and count 00.
  task automatic clearAndStart();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    //             start stop clear  count  en     run  done ovf
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h01, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h02, 2'b00, 1'b1, 1'b0, 1'b0};

    #1 rst = 1'b1;
    #2;
    checkOutput("reset", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    #9 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].clear);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_cnt_en,
                  vecs[i].exp_running, vecs[i].exp_done, vecs[i].exp_ovf);
    end

    // Carry into digit 1 on the 9 -> 10 tick.
    clearAndStart();
    idle(4 * 9);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("carry_pre", 8'h09, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("carry_tick", 8'h09, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("carry_post", 8'h10, 2'b00, 1'b1, 1'b0, 1'b0);

    // Wrap from 99 to 00 with a single-cycle overflow pulse.
    clearAndStart();
    idle(4 * 99);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovf_pre", 8'h99, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovf_tick", 8'h99, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovf_pulse", 8'h00, 2'b00, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovf_after", 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);

    // Target match at 03, then DONE ignores start and only clear leaves it.
    target_en = 1'b1;
    target    = 8'h03;
    clearAndStart();
    idle(4 * 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("match_pre", 8'h02, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("match_tick", 8'h02, 2'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("match_done", 8'h03, 2'b00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("done_start", 8'h03, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("done_hold", 8'h03, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(4);
    checkOutput("done_frozen", 8'h03, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("done_clear", 8'h03, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_clear", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Target 00 matches only on the wrap, with done and overflow together.
    target = 8'h00;
    clearAndStart();
    idle(4 * 100);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("match_zero", 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
    target_en = 1'b0;

    // Pause at prescaler 2 keeps the partial tick.
    clearAndStart();
    idle(4 * 5 + 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pause_stop", 8'h05, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("pause_hold%0d", i), 8'h05, 2'b00, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_start", 8'h05, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resume_p2", 8'h05, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resume_tick", 8'h05, 2'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resume_post", 8'h06, 2'b00, 1'b1, 1'b0, 1'b0);

    // stop and clear together on a tick at 07.
    clearAndStart();
    idle(4 * 7 + 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("stopclr_tick", 8'h07, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stopclr_post", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stopclr_hold", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

    // stop alone on a tick suppresses the increment.
    clearAndStart();
    idle(4 * 7 + 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_tick", 8'h07, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stop_post", 8'h07, 2'b00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at 42.
    clearAndStart();
    idle(4 * 42);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_pre", 8'h42, 2'b00, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_after", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
